// File: rtl/uart_loader.sv
// Block loader: drains a 512-byte receive buffer into instruction memory, one little-endian word per 4 bytes.
// Optional running byte checksum on load_sum is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter logic [31:0] IMEM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_fifo_full,
  output logic        rx_fifo_full_ack,
  output logic [8:0]  rx_fifo_ra,
  input  logic [7:0]  rx_fifo_rd,
  output logic [31:0] imem_wa,
  output logic [31:0] imem_wd,
  output logic        imem_wen,
  output logic        busy,
  output logic [7:0]  blocks_loaded,
  output logic [7:0]  load_sum,
  output logic [2:0]  dbg_state
);

  // Handshake: the buffer owner raises rx_fifo_full once a block is complete; the loader raises
  // rx_fifo_full_ack after the last word is written and drops it only once rx_fifo_full is seen low.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] ptr_q, ptr_d;
  logic [8:0]  ra_q, ra_d;
  logic [31:0] wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [7:0]  blocks_q, blocks_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    ptr_d    = ptr_q;
    ra_d     = ra_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    blocks_d = blocks_q;
    case (state_q)
      IDLE: begin
        if (rx_fifo_full) begin
          state_d = FETCH;
          idx_d   = 9'd0;
          ra_d    = 9'd0;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        case (idx_q[1:0])
          2'd0:    word_d[7:0]   = rx_fifo_rd;
          2'd1:    word_d[15:8]  = rx_fifo_rd;
          2'd2:    word_d[23:16] = rx_fifo_rd;
          default: word_d[31:24] = rx_fifo_rd;
        endcase
        idx_d = idx_q + 9'd1;
        if (idx_q[1:0] == 2'd3) begin
          state_d = WRITE;
          wa_d    = ptr_q;
          wd_d    = {rx_fifo_rd, word_q[23:0]};
        end else begin
          state_d = FETCH;
          ra_d    = idx_q + 9'd1;
        end
      end
      WRITE: begin
        ptr_d = ptr_q + 32'd1;
        // The byte index wraps to 0 only after byte 511, i.e. after word 127.
        if (idx_q == 9'd0) begin
          state_d = ACK;
        end else begin
          state_d = FETCH;
          ra_d    = idx_q;
        end
      end
      ACK: begin
        if (!rx_fifo_full) begin
          state_d  = IDLE;
          blocks_d = (blocks_q == 8'hFF) ? blocks_q : blocks_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 9'd0;
      word_q   <= 32'd0;
      ptr_q    <= IMEM_BASE;
      ra_q     <= 9'd0;
      wa_q     <= IMEM_BASE;
      wd_q     <= 32'd0;
      blocks_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      ptr_q    <= ptr_d;
      ra_q     <= ra_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      blocks_q <= blocks_d;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == CAPTURE) begin
      sum_d = sum_q + rx_fifo_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign load_sum = sum_q;
`else
  assign load_sum = 8'd0;
`endif

  assign rx_fifo_full_ack = (state_q == ACK);
  assign imem_wen         = (state_q == WRITE);
  assign busy             = (state_q != IDLE);
  assign rx_fifo_ra       = ra_q;
  assign imem_wa          = wa_q;
  assign imem_wd          = wd_q;
  assign blocks_loaded    = blocks_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: scoreboard of expected {imem_wa, imem_wd} writes checked by an independent monitor.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_fifo_full;
  logic        rx_fifo_full_ack;
  logic [8:0]  rx_fifo_ra;
  logic [7:0]  rx_fifo_rd;
  logic [31:0] imem_wa;
  logic [31:0] imem_wd;
  logic        imem_wen;
  logic        busy;
  logic [7:0]  blocks_loaded;
  logic [7:0]  load_sum;
  logic [2:0]  dbg_state;

  logic [7:0]  fifo_mem [512];
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  bit          first_seen = 1'b0;

  uart_loader #(.IMEM_BASE(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .rx_fifo_full(rx_fifo_full), .rx_fifo_full_ack(rx_fifo_full_ack),
    .rx_fifo_ra(rx_fifo_ra), .rx_fifo_rd(rx_fifo_rd), .imem_wa(imem_wa), .imem_wd(imem_wd),
    .imem_wen(imem_wen), .busy(busy), .blocks_loaded(blocks_loaded), .load_sum(load_sum),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter / buffer read port with one cycle of latency
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rx_fifo_rd <= fifo_mem[rx_fifo_ra];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe pops one expected entry
  always @(posedge clk) begin
    #1;
    if (imem_wen === 1'b1) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got wa=%0h wd=%0h with no write expected", imem_wa, imem_wd);
      end else begin
        check("imem_write", {imem_wa, imem_wd}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'((4 * i) & 255);
    b1 = 8'((4 * i + 1) & 255);
    b2 = 8'((4 * i + 2) & 255);
    b3 = 8'((4 * i + 3) & 255);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_words(input logic [31:0] base, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back({base + 32'(i), word_of(i)});
  endtask

  // driver: run one full block; ack is held for hold_cycles extra cycles with rx_fifo_full still high
  task automatic run_block(input logic [7:0] exp_blocks, input int hold_cycles);
    int start;
    int n;
    @(negedge clk);
    start        = cyc;
    first_seen   = 1'b0;
    rx_fifo_full = 1'b1;
    n = 0;
    while (rx_fifo_full_ack !== 1'b1 && n < 1300) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", 64'(cyc - start), 64'd1153);
    check("first_write_latency", 64'(first_cyc - start), 64'd9);
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      check("ack_held", {61'd0, dbg_state}, 64'd4);
      check("ack_held_out", {63'd0, rx_fifo_full_ack}, 64'd1);
    end
    rx_fifo_full = 1'b0;
    @(negedge clk);
    check("ack_released", {62'd0, rx_fifo_full_ack, busy}, 64'd0);
    check("blocks_loaded", {56'd0, blocks_loaded}, {56'd0, exp_blocks});
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic [7:0] exp_sum;
    for (int i = 0; i < 512; i++) fifo_mem[i] = 8'(i & 255);
    reset        = 1'b1;
    rx_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", {63'd0, rx_fifo_full_ack}, 64'd0);
    check("rst_wen", {63'd0, imem_wen}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ra", {55'd0, rx_fifo_ra}, 64'd0);
    check("rst_wd", {32'd0, imem_wd}, 64'd0);
    check("rst_wa", {32'd0, imem_wa}, 64'd0);
    check("rst_blocks", {56'd0, blocks_loaded}, 64'd0);
    check("rst_sum", {56'd0, load_sum}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    reset = 1'b0;

    // block 1: first word 03020100 at 0, word 127 FFFEFDFC at 127
    push_words(32'd0, 128);
    run_block(8'd1, 0);
    // block 2 immediately after: contiguous addresses 128..255
    push_words(32'd128, 128);
    run_block(8'd2, 0);
    // block 3 with rx_fifo_full lingering 5 cycles into ACK
    push_words(32'd256, 128);
    run_block(8'd3, 5);
    repeat (20) @(negedge clk);
    check("no_extra_block", {56'd0, blocks_loaded}, 64'd3);
    check("idle_after_hold", {63'd0, busy}, 64'd0);
    check("sum_after_blocks", {56'd0, load_sum}, 64'd0);

    // block 4: reset right after the 40th word (words 0..39) is written
    push_words(32'd384, 40);
    @(negedge clk);
    rx_fifo_full = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("forty_words_written", 64'(exp_q.size()), 64'd0);
`ifdef UART_LOADER_CHECKSUM_EN
    exp_sum = 8'hB0;
`else
    exp_sum = 8'h00;
`endif
    check("partial_sum", {56'd0, load_sum}, {56'd0, exp_sum});
    reset        = 1'b1;
    rx_fifo_full = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_wa", {32'd0, imem_wa}, 64'd0);
    check("mid_rst_wen", {63'd0, imem_wen}, 64'd0);
    check("mid_rst_state", {61'd0, dbg_state}, 64'd0);
    check("mid_rst_blocks", {56'd0, blocks_loaded}, 64'd0);
    check("mid_rst_sum", {56'd0, load_sum}, 64'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // after reset the pointer restarts at IMEM_BASE
    push_words(32'd0, 128);
    run_block(8'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter IMEM_BASE, default 32'h0000_0000, meaning the word address of the first instruction word written.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port rx_fifo_full, input, 1, meaning the 512-byte receive buffer holds a complete block.
REQ-005 SHALL have port rx_fifo_full_ack, output, 1, meaning the block is consumed and the buffer may be cleared.
REQ-006 SHALL have port rx_fifo_ra, output, 9, meaning the buffer read byte address.
REQ-007 SHALL have port rx_fifo_rd, input, 8, meaning buffer read data, valid one cycle after rx_fifo_ra.
REQ-008 SHALL have port imem_wa, output, 32, meaning the instruction memory word address.
REQ-009 SHALL have port imem_wd, output, 32, meaning the instruction memory write data.
REQ-010 SHALL have port imem_wen, output, 1, meaning the instruction memory write strobe, one cycle per word.
REQ-011 SHALL have port busy, output, 1, meaning the loader is not IDLE; used to hold the core.
REQ-012 SHALL have port blocks_loaded, output, 8, meaning the count of completed blocks.
REQ-013 SHALL have port load_sum, output, 8, meaning the running byte checksum (see Configuration).

Function
REQ-014 SHALL implement states IDLE, FETCH, CAPTURE, WRITE and ACK.
REQ-015 IDLE SHALL go to FETCH when rx_fifo_full=1, with the byte index cleared to 0; otherwise it SHALL stay in IDLE.
REQ-016 FETCH SHALL drive rx_fifo_ra=byte index for one cycle, then go to CAPTURE.
REQ-017 CAPTURE SHALL latch rx_fifo_rd into byte lane (index mod 4) of the word register and increment the index.
REQ-018 Byte packing SHALL be little-endian: byte 4k goes to bits [7:0] and byte 4k+3 goes to bits [31:24].
REQ-019 After CAPTURE of lane 3 the FSM SHALL go to WRITE; otherwise it SHALL return to FETCH.
REQ-020 WRITE SHALL assert imem_wen=1 for exactly one cycle with imem_wd=word and imem_wa=word pointer.
REQ-021 In WRITE, the word pointer SHALL increment by 1, wrapping modulo 2^32.
REQ-022 WRITE SHALL go to ACK after word 127 of the block; otherwise it SHALL go to FETCH.
REQ-023 Per block, the first imem_wen SHALL occur 9 cycles after IDLE exits, with 9 cycles per word and 1152 cycles to the last write.
REQ-024 ACK SHALL hold rx_fifo_full_ack=1 until rx_fifo_full=0 is sampled; then it SHALL deassert ack, increment blocks_loaded (saturating at 255) and go to IDLE.
REQ-025 The word pointer SHALL persist across blocks, so consecutive blocks load contiguous memory.
REQ-026 rx_fifo_full rising while not IDLE SHALL be ignored until IDLE.
REQ-027 rx_fifo_full falling mid-block SHALL NOT abort the block; the remaining bytes SHALL still be read and written.
REQ-028 busy SHALL equal 1 in every state except IDLE.
REQ-029 rx_fifo_ra SHALL be held at the last driven value outside FETCH.
REQ-030 imem_wd and imem_wa SHALL be held at their last values outside WRITE.

Reset
REQ-031 On reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-block.
REQ-032 On reset, the outputs SHALL be: rx_fifo_full_ack=0, imem_wen=0, busy=0, rx_fifo_ra=0, imem_wd=0, blocks_loaded=0 and load_sum=0.
REQ-033 On reset, imem_wa and the word pointer SHALL return to IMEM_BASE.
REQ-034 Reset SHALL take priority over all other inputs.

Configuration
REQ-035 Macro UART_LOADER_CHECKSUM_EN SHALL select the checksum feature.
REQ-036 With UART_LOADER_CHECKSUM_EN defined, load_sum SHALL add each captured byte modulo 256 in CAPTURE, accumulating across blocks.
REQ-037 Without UART_LOADER_CHECKSUM_EN, load_sum SHALL be constant 0 and no adder SHALL be synthesised.

Verification
REQ-038 A bench SHALL apply: reset for 2 cycles -> all outputs at reset values, state IDLE.
REQ-039 A bench SHALL apply: a buffer preloaded with byte n = n[7:0] and rx_fifo_full=1 -> first write at imem_wa=0 with imem_wd=32'h03020100; word 127 = 32'hFFFEFDFC; ack asserted after 1152+ cycles; blocks_loaded=1.
REQ-040 A bench SHALL apply: two back-to-back blocks -> the second block writes imem_wa 128..255; blocks_loaded=2.
REQ-041 A bench SHALL apply: rx_fifo_full held 1 for 5 cycles after ack -> ack held for those 5 cycles, then IDLE with no extra block loaded.
REQ-042 A bench SHALL apply: reset=1 at word 40 -> the next cycle has busy=0, imem_wa=IMEM_BASE and no further imem_wen.
REQ-043 A bench SHALL apply, with UART_LOADER_CHECKSUM_EN defined: the REQ-039 block -> load_sum=8'h00 (sum 0..255 twice, mod 256); without the macro, load_sum stays 0.
